serdesphy_ana_cdr_pi: RTL and testbench

//  Parametrised digital bang-bang CDR for the RX path. Alexander PD on data/edge samples,

---
 rtl/serdesphy_ana_cdr_pi.sv | 193 +++++++++++++++++++
 tb/tb_serdesphy_ana_cdr_pi.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_ana_cdr_pi.sv
// Digital bang-bang CDR for the RX path: Alexander phase detector, windowed majority
// vote, proportional+integral loop filter, wrapping PI code and lock/freeze supervision.
module serdesphy_ana_cdr_pi #(
    parameter int PHASE_W    = 8,
    parameter int INT_W      = 12,
    parameter int INT_SHIFT  = 4,
    parameter int VOTE_LEN   = 8,
    parameter int LOCK_TOL   = 1,
    parameter int UNLOCK_TOL = 4,
    parameter int LOCK_WIN   = 16
) (
    input  logic               clk_240m_rx,
    input  logic               rst,
    input  logic               enable,
    input  logic               cdr_clear,
    input  logic               freeze,
    input  logic               fast_lock,
    input  logic [2:0]         kp_sel,
    input  logic [2:0]         ki_sel,
    input  logic               samp_valid,
    input  logic               samp_data,
    input  logic               samp_edge,
    output logic [PHASE_W-1:0] pi_code,
    output logic               pi_code_valid,
    output logic [INT_W-1:0]   integ_out,
    output logic               cdr_lock,
    output logic               lock_lost,
    output logic [1:0]         cdr_state
);

    localparam int SUM_W = $clog2(VOTE_LEN) + 2;
    localparam int CNT_W = $clog2(VOTE_LEN);
    localparam int LCK_W = $clog2(LOCK_WIN + 1);
    localparam logic [PHASE_W-1:0]    PI_MID  = {1'b1, {(PHASE_W-1){1'b0}}};
    localparam logic signed [INT_W:0] INT_MAX = (INT_W+1)'((1 << (INT_W-1)) - 1);
    localparam logic signed [INT_W:0] INT_MIN = -INT_MAX;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ACQ     = 2'b01,
        S_LOCKED  = 2'b10,
        S_FREEZE  = 2'b11
    } state_t;

    state_t                          state, state_nxt;
    logic                            d_prev, have_prev;
    logic signed [SUM_W-1:0]         win_sum, vote, sum_next;
    logic [SUM_W-1:0]                sum_abs;
    logic [CNT_W-1:0]                win_cnt;
    logic                            upd_pend, upd_up, upd_dn, upd_quiet, upd_loud;
    logic [LCK_W-1:0]                lock_cnt, cnt_inc;
    logic signed [INT_W-1:0]         integ, integ_new;
    logic signed [INT_W:0]           integ_ext, ki_step, integ_sum;
    logic signed [INT_W+PHASE_W-1:0] int_wide, int_sh;
    logic [3:0]                      kp_raw, kp_eff;
    logic [PHASE_W-1:0]              kp_step, kp_term, pi_next;
    logic                            active, win_close, apply, lock_set, lock_drop;

    assign active    = enable && !freeze && (state == S_ACQ || state == S_LOCKED);
    assign win_close = active && samp_valid && (win_cnt == CNT_W'(VOTE_LEN - 1));
    assign apply     = upd_pend && enable && !freeze;
    assign lock_set  = apply && upd_quiet && (cnt_inc == LCK_W'(LOCK_WIN));
    assign lock_drop = apply && upd_loud && cdr_lock;
    assign integ_out = integ;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        vote = '0;
        if (have_prev && (d_prev != samp_data))
            vote = (samp_edge == d_prev) ? SUM_W'(1) : '1;
        sum_next = win_sum + vote;
        sum_abs  = sum_next[SUM_W-1] ? -sum_next : sum_next;
    end

    // Loop filter: the integrator saturates symmetrically, the phase code wraps freely.
    always_comb begin
        integ_ext = {integ[INT_W-1], integ};
        ki_step   = (INT_W+1)'(1) << ki_sel;
        integ_sum = integ_ext;
        if (upd_up)
            integ_sum = integ_ext + ki_step;
        else if (upd_dn)
            integ_sum = integ_ext - ki_step;
        if (integ_sum > INT_MAX)
            integ_sum = INT_MAX;
        else if (integ_sum < INT_MIN)
            integ_sum = INT_MIN;
        integ_new = integ_sum[INT_W-1:0];

        kp_raw  = {1'b0, kp_sel} + {3'b000, fast_lock & ~cdr_lock};
        kp_eff  = (kp_raw > 4'(PHASE_W - 2)) ? 4'(PHASE_W - 2) : kp_raw;
        kp_step = PHASE_W'(1) << kp_eff;
        kp_term = '0;
        if (upd_up)
            kp_term = kp_step;
        else if (upd_dn)
            kp_term = '0 - kp_step;

        int_wide = {{PHASE_W{integ_new[INT_W-1]}}, integ_new};
        int_sh   = int_wide >>> INT_SHIFT;
        pi_next  = pi_code + kp_term + int_sh[PHASE_W-1:0];
        cnt_inc  = (lock_cnt == LCK_W'(LOCK_WIN)) ? lock_cnt : lock_cnt + 1'b1;
    end

    always_ff @(posedge clk_240m_rx or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else if (cdr_clear)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (enable) state_nxt = S_ACQ;
            S_ACQ:    if (!enable) state_nxt = S_IDLE;
                      else if (freeze) state_nxt = S_FREEZE;
                      else if (lock_set) state_nxt = S_LOCKED;
            S_LOCKED: if (!enable) state_nxt = S_IDLE;
                      else if (freeze) state_nxt = S_FREEZE;
                      else if (lock_drop) state_nxt = S_ACQ;
            S_FREEZE: if (!enable) state_nxt = S_IDLE;
                      else if (!freeze) state_nxt = cdr_lock ? S_LOCKED : S_ACQ;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb cdr_state = state;

    always_ff @(posedge clk_240m_rx or posedge rst) begin
        if (rst) begin
            pi_code <= PI_MID;   pi_code_valid <= 1'b0;  integ <= '0;
            cdr_lock <= 1'b0;    lock_lost <= 1'b0;      lock_cnt <= '0;
            d_prev <= 1'b0;      have_prev <= 1'b0;      win_sum <= '0;   win_cnt <= '0;
            upd_pend <= 1'b0;    upd_up <= 1'b0;         upd_dn <= 1'b0;
            upd_quiet <= 1'b0;   upd_loud <= 1'b0;
        end else if (cdr_clear) begin
            pi_code <= PI_MID;   pi_code_valid <= 1'b0;  integ <= '0;
            cdr_lock <= 1'b0;    lock_lost <= 1'b0;      lock_cnt <= '0;
            d_prev <= 1'b0;      have_prev <= 1'b0;      win_sum <= '0;   win_cnt <= '0;
            upd_pend <= 1'b0;    upd_up <= 1'b0;         upd_dn <= 1'b0;
            upd_quiet <= 1'b0;   upd_loud <= 1'b0;
        end else begin
            pi_code_valid <= 1'b0;
            lock_lost     <= 1'b0;
            upd_pend      <= 1'b0;
            if (!enable) begin
                cdr_lock  <= 1'b0;
                lock_cnt  <= '0;
                win_sum   <= '0;
                win_cnt   <= '0;
                have_prev <= 1'b0;
            end else begin
                if (freeze || state == S_FREEZE) begin
                    win_sum <= '0;
                    win_cnt <= '0;
                end else if (active && samp_valid) begin
                    d_prev    <= samp_data;
                    have_prev <= 1'b1;
                    if (win_close) begin
                        win_sum   <= '0;
                        win_cnt   <= '0;
                        upd_pend  <= 1'b1;
                        upd_up    <= !sum_next[SUM_W-1] && (sum_next != '0);
                        upd_dn    <= sum_next[SUM_W-1];
                        upd_quiet <= sum_abs <= SUM_W'(LOCK_TOL);
                        upd_loud  <= sum_abs > SUM_W'(UNLOCK_TOL);
                    end else begin
                        win_sum <= sum_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                if (apply) begin
                    integ         <= integ_new;
                    pi_code       <= pi_next;
                    pi_code_valid <= 1'b1;
                    if (upd_quiet) begin
                        lock_cnt <= cnt_inc;
                        if (cnt_inc == LCK_W'(LOCK_WIN))
                            cdr_lock <= 1'b1;
                    end else if (upd_loud) begin
                        lock_cnt  <= '0;
                        cdr_lock  <= 1'b0;
                        lock_lost <= cdr_lock;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serdesphy_ana_cdr_pi.sv
// Self-checking bench for serdesphy_ana_cdr_pi: directed scenarios plus randomized traffic,
// all compared against a vote-queue reference model of the CDR loop.
module tb_serdesphy_ana_cdr_pi;

    localparam int PHASE_W = 8, INT_W = 12, INT_SHIFT = 4, VOTE_LEN = 8;
    localparam int LOCK_TOL = 1, UNLOCK_TOL = 4, LOCK_WIN = 16;
    localparam int INT_LIM = (1 << (INT_W - 1)) - 1;

    logic               clk_240m_rx = 1'b0;
    logic               rst = 1'b1, enable = 1'b0, cdr_clear = 1'b0, freeze = 1'b0;
    logic               fast_lock = 1'b0;
    logic [2:0]         kp_sel = 3'd0, ki_sel = 3'd0;
    logic               samp_valid = 1'b0, samp_data = 1'b0, samp_edge = 1'b0;
    logic [PHASE_W-1:0] pi_code;
    logic               pi_code_valid, cdr_lock, lock_lost;
    logic [INT_W-1:0]   integ_out;
    logic [1:0]         cdr_state;

    always #5 clk_240m_rx = ~clk_240m_rx;

    serdesphy_ana_cdr_pi dut (
        .clk_240m_rx(clk_240m_rx), .rst(rst), .enable(enable), .cdr_clear(cdr_clear),
        .freeze(freeze), .fast_lock(fast_lock), .kp_sel(kp_sel), .ki_sel(ki_sel),
        .samp_valid(samp_valid), .samp_data(samp_data), .samp_edge(samp_edge),
        .pi_code(pi_code), .pi_code_valid(pi_code_valid), .integ_out(integ_out),
        .cdr_lock(cdr_lock), .lock_lost(lock_lost), .cdr_state(cdr_state)
    );

    int n_checks = 0, n_pass = 0, cyc = 0;
    logic cur_d = 1'b0;

    // Reference model: votes collected in a queue, loop state as plain integers.
    int m_pi, m_int, m_mode, m_prev, m_cnt, m_pdir, m_pabs;
    bit m_lock, m_lost, m_valid, m_pend;
    int m_votes[$];

    logic [24:0] dut_vec;
    assign dut_vec = {pi_code, integ_out, cdr_lock, lock_lost, pi_code_valid, cdr_state};

    function automatic logic [24:0] exp_vec();
        return {m_pi[7:0], m_int[11:0], m_lock, m_lost, m_valid, m_mode[1:0]};
    endfunction

    function automatic void model_reset();
        m_pi = 1 << (PHASE_W - 1); m_int = 0; m_mode = 0; m_prev = -1; m_cnt = 0;
        m_pdir = 0; m_pabs = 0; m_lock = 0; m_lost = 0; m_valid = 0; m_pend = 0;
        m_votes.delete();
    endfunction

    function automatic void model_step();
        int old_mode, pd, pa, s, v, kp;
        bit old_lock, was_pend;
        m_valid = 0;
        m_lost  = 0;
        if (cdr_clear) begin
            model_reset();
            return;
        end
        if (!enable) begin
            m_mode = 0; m_lock = 0; m_cnt = 0; m_prev = -1; m_pend = 0;
            m_votes.delete();
            return;
        end
        old_mode = m_mode; old_lock = m_lock; was_pend = m_pend;
        pd = m_pdir; pa = m_pabs; m_pend = 0;
        if (freeze || old_mode == 3) begin
            m_votes.delete();
        end else if ((old_mode == 1 || old_mode == 2) && samp_valid) begin
            v = 0;
            if (m_prev >= 0 && m_prev != int'(samp_data))
                v = (int'(samp_edge) == m_prev) ? 1 : -1;
            m_prev = int'(samp_data);
            m_votes.push_back(v);
            if (m_votes.size() == VOTE_LEN) begin
                s = 0;
                foreach (m_votes[i]) s += m_votes[i];
                m_pdir = (s > 0) ? 1 : (s < 0) ? -1 : 0;
                m_pabs = (s < 0) ? -s : s;
                m_pend = 1;
                m_votes.delete();
            end
        end
        if (was_pend && !freeze) begin
            m_int += pd * (1 << ki_sel);
            if (m_int > INT_LIM) m_int = INT_LIM;
            if (m_int < -INT_LIM) m_int = -INT_LIM;
            kp = int'(kp_sel) + ((fast_lock && !old_lock) ? 1 : 0);
            if (kp > PHASE_W - 2) kp = PHASE_W - 2;
            m_pi = m_pi + pd * (1 << kp) + (m_int >>> INT_SHIFT);
            m_pi = ((m_pi % (1 << PHASE_W)) + (1 << PHASE_W)) % (1 << PHASE_W);
            m_valid = 1;
            if (pa <= LOCK_TOL) begin
                if (m_cnt < LOCK_WIN) m_cnt++;
                if (m_cnt == LOCK_WIN) m_lock = 1;
            end else if (pa > UNLOCK_TOL) begin
                m_cnt = 0;
                if (old_lock) begin
                    m_lock = 0;
                    m_lost = 1;
                end
            end
        end
        case (old_mode)
            0:       m_mode = 1;
            3:       m_mode = freeze ? 3 : (m_lock ? 2 : 1);
            default: m_mode = freeze ? 3 : (m_lock ? 2 : 1);
        endcase
    endfunction

    task automatic step_clk();
        @(posedge clk_240m_rx);
        model_step();
        cyc++;
        @(negedge clk_240m_rx);
    endtask

    // kind: 0 no sample, 1 early transition, 2 late transition, 3 no transition
    task automatic drive(input int kind);
        samp_valid = (kind != 0);
        case (kind)
            1: begin samp_edge = cur_d; cur_d = ~cur_d; samp_data = cur_d; end
            2: begin cur_d = ~cur_d; samp_data = cur_d; samp_edge = cur_d; end
            3: begin samp_data = cur_d; samp_edge = 1'($urandom); end
            default: ;
        endcase
        step_clk();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_240m_rx);
        model_reset();
        rst = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
        else n_pass++;
        enable = 1'b1; kp_sel = 3'd2; ki_sel = 3'd0;
        drive(0);
        for (int i = 0; i < 3; i++) drive(1);
        #2 rst = 1'b1;
        #1 model_reset();
        n_checks++;
        if ({pi_code, integ_out, cdr_lock, cdr_state} !== {8'h80, 12'h000, 1'b0, 2'b00})
            $display("FAIL reset_mid_window got=%h exp=%h", {pi_code, integ_out, cdr_lock, cdr_state},
                     {8'h80, 12'h000, 1'b0, 2'b00});
        else n_pass++;
        @(negedge clk_240m_rx);
        rst = 1'b0;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_first_window();
        drive(0);
        for (int i = 0; i < VOTE_LEN; i++) begin
            drive(1);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL first_window cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        drive(0);
        n_checks++;
        if ({pi_code, integ_out, pi_code_valid} !== {8'h84, 12'd1, 1'b1})
            $display("FAIL first_update got=%h exp=%h", {pi_code, integ_out, pi_code_valid}, {8'h84, 12'd1, 1'b1});
        else n_pass++;
        drive(0);
        n_checks++;
        if (pi_code_valid !== 1'b0) $display("FAIL update_pulse_width got=%b exp=0", pi_code_valid);
        else n_pass++;
    endtask

    task automatic test_lock();
        int sent = 0;
        bit early = 1'b1;
        while (sent < LOCK_WIN * VOTE_LEN) begin
            if ($urandom_range(0, 3) == 0) drive(0);
            else begin
                drive(early ? 1 : 2);
                early = ~early;
                sent++;
            end
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL lock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (cdr_lock !== 1'b0) $display("FAIL lock_too_early got=%b exp=0", cdr_lock);
        else n_pass++;
        drive(0);
        n_checks++;
        if ({cdr_lock, cdr_state} !== {1'b1, 2'b10})
            $display("FAIL lock_on_16th got=%b exp=%b", {cdr_lock, cdr_state}, {1'b1, 2'b10});
        else n_pass++;
    endtask

    task automatic test_unlock();
        for (int i = 0; i < VOTE_LEN; i++) drive(2);
        drive(0);
        n_checks++;
        if ({cdr_lock, lock_lost, cdr_state} !== {1'b0, 1'b1, 2'b01})
            $display("FAIL unlock got=%b exp=%b", {cdr_lock, lock_lost, cdr_state}, {1'b0, 1'b1, 2'b01});
        else n_pass++;
        drive(0);
        n_checks++;
        if (lock_lost !== 1'b0) $display("FAIL lock_lost_width got=%b exp=0", lock_lost);
        else n_pass++;
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL unlock_state cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_wrap();
        cdr_clear = 1'b1;
        drive(0);
        cdr_clear = 1'b0;
        kp_sel = 3'd6; ki_sel = 3'd0;
        drive(0);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < VOTE_LEN; i++) drive(2);
            drive(0);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL wrap_down cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (pi_code !== 8'hFE) $display("FAIL wrap_setup got=%h exp=fe", pi_code);
        else n_pass++;
        kp_sel = 3'd2; ki_sel = 3'd1;
        for (int i = 0; i < VOTE_LEN; i++) drive(1);
        drive(0);
        n_checks++;
        if ({pi_code, integ_out} !== {8'h02, 12'd0})
            $display("FAIL wrap_up got=%h exp=%h", {pi_code, integ_out}, {8'h02, 12'd0});
        else n_pass++;
    endtask

    task automatic test_saturate();
        kp_sel = 3'd6; ki_sel = 3'd7;
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < VOTE_LEN; i++) drive(1);
            drive(0);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL sat_pos cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (integ_out !== 12'd2047) $display("FAIL sat_pos_limit got=%0d exp=2047", integ_out);
        else n_pass++;
        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < VOTE_LEN; i++) drive(2);
            drive(0);
        end
        n_checks++;
        if (integ_out !== 12'h801) $display("FAIL sat_neg_limit got=%h exp=801", integ_out);
        else n_pass++;
    endtask

    task automatic test_freeze();
        int hold_pi = m_pi, hold_int = m_int;
        logic [19:0] held;
        held = {hold_pi[7:0], hold_int[11:0]};
        freeze = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1);
            n_checks++;
            if (pi_code_valid !== 1'b0 || {pi_code, integ_out} !== held)
                $display("FAIL freeze_hold cyc=%0d got=%h/%b exp=%h/0", cyc, {pi_code, integ_out}, pi_code_valid, held);
            else n_pass++;
        end
        n_checks++;
        if (cdr_state !== 2'b11) $display("FAIL freeze_state got=%b exp=11", cdr_state);
        else n_pass++;
        freeze = 1'b0;
        drive(0);
        n_checks++;
        if (dut_vec !== exp_vec()) $display("FAIL freeze_exit cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int budget = 400;
        int keep_pi;
        bit early = 1'b1;
        kp_sel = 3'd2; ki_sel = 3'd0; fast_lock = 1'b1;
        while (!m_lock && budget > 0) begin
            drive(early ? 1 : 2);
            early = ~early;
            budget--;
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reacq_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (!m_lock) $display("FAIL reacq_timeout got=%b exp=1", cdr_lock);
        else n_pass++;
        keep_pi = m_pi;
        enable = 1'b0;
        drive(1);
        n_checks++;
        if ({cdr_lock, lock_lost, cdr_state, pi_code} !== {1'b0, 1'b0, 2'b00, keep_pi[7:0]})
            $display("FAIL enable_drop got=%h exp=%h", {cdr_lock, lock_lost, cdr_state, pi_code},
                     {1'b0, 1'b0, 2'b00, keep_pi[7:0]});
        else n_pass++;
        enable = 1'b1;
        fast_lock = 1'b0;
        for (int i = 0; i < 3 * VOTE_LEN; i++) begin
            drive($urandom_range(0, 3));
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL reenable cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int pattern = 0;
        bit early = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 400 == 0) pattern = $urandom_range(0, 2);
            cdr_clear = ($urandom_range(0, 499) == 0);
            enable    = enable ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 7) == 0);
            freeze    = freeze ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) begin
                kp_sel    = 3'($urandom);
                ki_sel    = 3'($urandom_range(0, 3));
                fast_lock = 1'($urandom);
            end
            if ($urandom_range(0, 4) == 0) drive(0);
            else if (pattern == 0) begin
                drive(early ? 1 : 2);
                early = ~early;
            end else if (pattern == 1) drive($urandom_range(1, 3));
            else drive(($urandom_range(0, 5) == 0) ? 2 : 1);
            n_checks++;
            if (dut_vec !== exp_vec()) $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            else n_pass++;
        end
        cdr_clear = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_window();
        test_lock();
        test_unlock();
        test_wrap();
        test_saturate();
        test_freeze();
        test_enable_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1);
    end

endmodule
